// File: rtl/reg_dump_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_dump_ctrl_pkg
// Description : Shared constants, state encoding and beat type for the
//               register-dump controller and its output holding register.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_dump_ctrl_pkg;

  localparam int DUMP_BEATS         = 32;
  localparam int REG_ADDR_W         = 5;
  localparam int DATA_W             = 32;
  localparam int LD_W               = 6;       // holds 0..DUMP_BEATS inclusive
  localparam int DEF_TIMEOUT_CYCLES = 100000;

  // Controller states
  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_DUMP = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // One dump beat as held in the output register
  typedef struct packed {
    logic [DATA_W-1:0]     data;
    logic [REG_ADDR_W-1:0] idx;
    logic                  last;
  } dump_beat_t;

endpackage
`default_nettype wire

// File: rtl/reg_dump_oreg.sv
`default_nettype none
// ============================================================================
// Module      : reg_dump_oreg
// Description : Single-entry valid/ready holding register for dump beats.
//               Outputs come straight from flops, so ready never reaches
//               valid/data combinationally; ready only steers the next load.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_dump_oreg
  import reg_dump_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,      // capture i_beat; caller only asserts with o_can_load
  input  dump_beat_t i_beat,
  input  logic       i_ready,
  output logic       o_valid,
  output dump_beat_t o_beat,
  output logic       o_can_load,  // slot empty, or being drained this edge
  output logic       o_accept     // beat handed to the sink this edge
);

  logic       r_valid;
  dump_beat_t r_beat;

  assign o_can_load = ~r_valid | i_ready;
  assign o_accept   = r_valid & i_ready;
  assign o_valid    = r_valid;
  assign o_beat     = r_beat;

  // Load a new beat, or drop valid when the held beat drains with nothing behind it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_beat  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_beat  <= i_beat;
    end else if (o_accept) begin
      r_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : reg_dump_ctrl
// Description : Counts CPU run cycles until finish (or a timeout), then reads
//               all 32 registers through the test port and streams them out
//               over valid/ready, accumulating a mod-2^32 checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_dump_ctrl
  import reg_dump_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_finish,
  output logic [REG_ADDR_W-1:0] o_rdtaddr,
  input  logic [DATA_W-1:0]     i_rdtdata,
  output logic                  o_dump_valid,
  input  logic                  i_dump_ready,
  output logic [DATA_W-1:0]     o_dump_data,
  output logic [REG_ADDR_W-1:0] o_dump_idx,
  output logic                  o_dump_last,
  output logic [CNT_W-1:0]      o_cyc_cnt,
  output logic                  o_timeout,
  output logic [DATA_W-1:0]     o_checksum,
  output logic                  o_done
);

  localparam logic [CNT_W-1:0] c_TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LD_W-1:0]  c_LD_END       = LD_W'(DUMP_BEATS);
  localparam logic [LD_W-1:0]  c_LD_LAST      = LD_W'(DUMP_BEATS - 1);

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cyc_cnt;
  logic              r_timeout;
  logic [LD_W-1:0]   r_ld;
  logic [DATA_W-1:0] r_checksum;
  logic              r_done;

  logic       w_ld_more;
  logic       w_can_load;
  logic       w_load;
  logic       w_accept;
  dump_beat_t w_beat;
  dump_beat_t w_oreg_beat;

  // Loading continues until every register has been captured once
  assign w_ld_more = (r_ld < c_LD_END);
  assign w_load    = (r_state == ST_DUMP) && w_ld_more && w_can_load;
  assign w_beat    = {i_rdtdata, r_ld[REG_ADDR_W-1:0], (r_ld == c_LD_LAST)};

  // Address parks on the last register once the load counter runs off the end
  assign o_rdtaddr = w_ld_more ? r_ld[REG_ADDR_W-1:0] : REG_ADDR_W'(DUMP_BEATS - 1);

  reg_dump_oreg u_oreg (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_beat     (w_beat),
    .i_ready    (i_dump_ready),
    .o_valid    (o_dump_valid),
    .o_beat     (w_oreg_beat),
    .o_can_load (w_can_load),
    .o_accept   (w_accept)
  );

  assign o_dump_data = w_oreg_beat.data;
  assign o_dump_idx  = w_oreg_beat.idx;
  assign o_dump_last = w_oreg_beat.last;
  assign o_cyc_cnt   = r_cyc_cnt;
  assign o_timeout   = r_timeout;
  assign o_checksum  = r_checksum;
  assign o_done      = r_done;

  // Phase sequencing and run-cycle counting; finish beats a coincident timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RUN;
      r_cyc_cnt <= '0;
      r_timeout <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (i_finish) begin
            r_state <= ST_DUMP;
          end else if (r_cyc_cnt == c_TIMEOUT_LAST) begin
            r_state   <= ST_DUMP;
            r_timeout <= 1'b1;
            r_cyc_cnt <= r_cyc_cnt + 1'b1;
          end else begin
            r_cyc_cnt <= r_cyc_cnt + 1'b1;
          end
        end
        ST_DUMP: begin
          if (w_accept && o_dump_last) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

  // Register-file read pointer advances once per captured beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ld <= '0;
    end else if (w_load) begin
      r_ld <= r_ld + 1'b1;
    end
  end

  // Checksum covers exactly the beats the sink accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= r_checksum + o_dump_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_dump_ctrl
// Description : Self-checking bench for reg_dump_ctrl. Instance A uses the
//               default timeout, instance B a 16-cycle timeout. Expected
//               beats and checksums come from the register-file contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_dump_ctrl;
  import reg_dump_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic finish_a, finish_b, ready_g;
  int   sel_g;
  logic ready_a, ready_b;

  logic [31:0] regs_a [32];
  logic [31:0] regs_b [32];

  logic [4:0]  rdtaddr_a, rdtaddr_b, idx_a, idx_b;
  logic [31:0] rdtdata_a, rdtdata_b, data_a, data_b, cyc_a, cyc_b, sum_a, sum_b;
  logic        valid_a, valid_b, last_a, last_b, to_a, to_b, done_a, done_b;

  int nchk = 0;
  int nerr = 0;

  assign ready_a   = (sel_g == 0) ? ready_g : 1'b0;
  assign ready_b   = (sel_g == 1) ? ready_g : 1'b0;
  assign rdtdata_a = regs_a[rdtaddr_a];
  assign rdtdata_b = regs_b[rdtaddr_b];

  reg_dump_ctrl u_dut_a (
    .clk(clk), .rst_n(rst_n), .i_finish(finish_a),
    .o_rdtaddr(rdtaddr_a), .i_rdtdata(rdtdata_a),
    .o_dump_valid(valid_a), .i_dump_ready(ready_a),
    .o_dump_data(data_a), .o_dump_idx(idx_a), .o_dump_last(last_a),
    .o_cyc_cnt(cyc_a), .o_timeout(to_a), .o_checksum(sum_a), .o_done(done_a)
  );

  reg_dump_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(32)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .i_finish(finish_b),
    .o_rdtaddr(rdtaddr_b), .i_rdtdata(rdtdata_b),
    .o_dump_valid(valid_b), .i_dump_ready(ready_b),
    .o_dump_data(data_b), .o_dump_idx(idx_b), .o_dump_last(last_b),
    .o_cyc_cnt(cyc_b), .o_timeout(to_b), .o_checksum(sum_b), .o_done(done_b)
  );

  // Selected-instance view
  logic [4:0]  m_rdtaddr, m_idx;
  logic [31:0] m_data, m_cyc, m_sum;
  logic        m_valid, m_last, m_to, m_done;
  assign m_rdtaddr = (sel_g == 1) ? rdtaddr_b : rdtaddr_a;
  assign m_idx     = (sel_g == 1) ? idx_b     : idx_a;
  assign m_data    = (sel_g == 1) ? data_b    : data_a;
  assign m_cyc     = (sel_g == 1) ? cyc_b     : cyc_a;
  assign m_sum     = (sel_g == 1) ? sum_b     : sum_a;
  assign m_valid   = (sel_g == 1) ? valid_b   : valid_a;
  assign m_last    = (sel_g == 1) ? last_b    : last_a;
  assign m_to      = (sel_g == 1) ? to_b      : to_a;
  assign m_done    = (sel_g == 1) ? done_b    : done_a;

  // Accepted beats, in acceptance order
  logic [31:0] q_data [$];
  logic [4:0]  q_idx  [$];
  logic        q_last [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_regs(input int sel, input bit rnd);
    for (int i = 0; i < 32; i++) begin
      if (sel == 1) regs_b[i] = rnd ? $urandom : 32'(i) * 32'h0101_0101;
      else          regs_a[i] = rnd ? $urandom : 32'(i) * 32'h0101_0101;
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    finish_a = 1'b0;
    finish_b = 1'b0;
    ready_g  = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Model: the sum of every register, wrapping at 32 bits
  function automatic logic [31:0] model_sum(input int sel);
    logic [31:0] s = '0;
    for (int i = 0; i < 32; i++) s += (sel == 1) ? regs_b[i] : regs_a[i];
    return s;
  endfunction

  // Model: beat i must carry register i, index i, last only on 31
  function automatic int beat_errors(input int sel);
    int e = 0;
    for (int i = 0; i < 32; i++) begin
      if (i >= q_data.size()) e++;
      else if (q_data[i] !== ((sel == 1) ? regs_b[i] : regs_a[i]) ||
               q_idx[i] !== 5'(i) || q_last[i] !== (i == 31)) e++;
    end
    if (q_data.size() > 32) e += q_data.size() - 32;
    return e;
  endfunction

  // Drive ready (0: always high, 1: 1,0,1,0..., 2: random) and log accepted beats
  task automatic collect(input int mode, input int max_beats, input int budget,
                         output int cycles, output int hold_err, output bit hit_budget);
    logic r, pv, pl;
    logic [31:0] pd;
    logic [4:0]  pi;
    cycles = 0; hold_err = 0; hit_budget = 1'b1;
    q_data.delete(); q_idx.delete(); q_last.delete();
    for (int c = 0; c < budget; c++) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = (c % 2 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      ready_g = r;
      pv = m_valid; pd = m_data; pi = m_idx; pl = m_last;
      tick();
      cycles++;
      if (pv && r) begin
        q_data.push_back(pd); q_idx.push_back(pi); q_last.push_back(pl);
      end else if (pv) begin
        if (!(m_valid === 1'b1 && m_data === pd && m_idx === pi && m_last === pl)) hold_err++;
      end
      if (m_done === 1'b1 || q_data.size() >= max_beats) begin
        hit_budget = 1'b0;
        break;
      end
    end
    ready_g = 1'b0;
  endtask

  task automatic test_reset();
    sel_g = 0;
    rst_n = 1'b0; finish_a = 1'b1; finish_b = 1'b0; ready_g = 1'b1;
    repeat (3) tick();
    nchk++;
    if ({rdtaddr_a, valid_a, data_a, idx_a, last_a, cyc_a, to_a, sum_a, done_a} !== '0) begin
      nerr++; $display("FAIL reset_a: got %h expected 0",
        {rdtaddr_a, valid_a, data_a, idx_a, last_a, cyc_a, to_a, sum_a, done_a});
    end
    nchk++;
    if ({rdtaddr_b, valid_b, data_b, idx_b, last_b, cyc_b, to_b, sum_b, done_b} !== '0) begin
      nerr++; $display("FAIL reset_b: got %h expected 0",
        {rdtaddr_b, valid_b, data_b, idx_b, last_b, cyc_b, to_b, sum_b, done_b});
    end
  endtask

  task automatic test_finish_run();
    int cyc, herr; bit hb;
    sel_g = 0; fill_regs(0, 1'b0); do_reset();
    repeat (10) tick();
    nchk++;
    if (cyc_a !== 32'd10) begin nerr++; $display("FAIL run_cnt: got %0d expected 10", cyc_a); end
    finish_a = 1'b1;
    collect(0, 32, 200, cyc, herr, hb);
    nchk++;
    if (hb !== 1'b0) begin nerr++; $display("FAIL run_budget: got %0d expected 0", hb); end
    nchk++;
    if (cyc !== 34) begin nerr++; $display("FAIL run_latency: got %0d expected 34", cyc); end
    nchk++;
    if (beat_errors(0) !== 0) begin nerr++; $display("FAIL run_beats: got %0d bad expected 0", beat_errors(0)); end
    nchk++;
    if (sum_a !== model_sum(0)) begin nerr++; $display("FAIL run_sum: got %h expected %h", sum_a, model_sum(0)); end
    nchk++;
    if ({cyc_a, to_a, done_a, valid_a} !== {32'd10, 1'b0, 1'b1, 1'b0}) begin
      nerr++; $display("FAIL run_end: got cyc=%0d to=%0d done=%0d valid=%0d expected 10 0 1 0", cyc_a, to_a, done_a, valid_a);
    end
  endtask

  task automatic test_ready_toggle();
    int cyc, herr; bit hb;
    sel_g = 0; fill_regs(0, 1'b0); do_reset();
    repeat (3) tick();
    finish_a = 1'b1;
    collect(1, 32, 400, cyc, herr, hb);
    nchk++;
    if (hb !== 1'b0) begin nerr++; $display("FAIL tog_budget: got %0d expected 0", hb); end
    nchk++;
    if (herr !== 0) begin nerr++; $display("FAIL tog_hold: got %0d expected 0", herr); end
    nchk++;
    if (beat_errors(0) !== 0) begin nerr++; $display("FAIL tog_beats: got %0d bad expected 0", beat_errors(0)); end
    nchk++;
    if (sum_a !== model_sum(0)) begin nerr++; $display("FAIL tog_sum: got %h expected %h", sum_a, model_sum(0)); end
  endtask

  task automatic test_stall();
    int cyc, herr; bit hb;
    sel_g = 0; fill_regs(0, 1'b1); do_reset();
    finish_a = 1'b1;
    tick(); tick();
    for (int c = 0; c < 100; c++) begin
      nchk++;
      if ({valid_a, data_a, idx_a, rdtaddr_a} !== {1'b1, regs_a[0], 5'd0, 5'd1}) begin
        nerr++; $display("FAIL stall_hold: cycle %0d got v=%0d d=%h i=%0d a=%0d expected 1 %h 0 1",
          c, valid_a, data_a, idx_a, rdtaddr_a, regs_a[0]);
      end
      tick();
    end
    collect(0, 32, 200, cyc, herr, hb);
    nchk++;
    if (beat_errors(0) !== 0) begin nerr++; $display("FAIL stall_beats: got %0d bad expected 0", beat_errors(0)); end
    nchk++;
    if ({done_a, sum_a} !== {1'b1, model_sum(0)}) begin
      nerr++; $display("FAIL stall_end: got done=%0d sum=%h expected 1 %h", done_a, sum_a, model_sum(0));
    end
  endtask

  task automatic test_timeout();
    int cyc, herr; bit hb;
    sel_g = 1; fill_regs(1, 1'b1); do_reset();
    repeat (15) tick();
    nchk++;
    if ({to_b, cyc_b} !== {1'b0, 32'd15}) begin nerr++; $display("FAIL to_pre: got to=%0d cyc=%0d expected 0 15", to_b, cyc_b); end
    tick();
    nchk++;
    if ({to_b, cyc_b} !== {1'b1, 32'd16}) begin nerr++; $display("FAIL to_hit: got to=%0d cyc=%0d expected 1 16", to_b, cyc_b); end
    collect(2, 32, 600, cyc, herr, hb);
    nchk++;
    if ({hb, herr} !== {1'b0, 32'd0}) begin nerr++; $display("FAIL to_flow: got budget=%0d hold=%0d expected 0 0", hb, herr); end
    nchk++;
    if (beat_errors(1) !== 0) begin nerr++; $display("FAIL to_beats: got %0d bad expected 0", beat_errors(1)); end
    nchk++;
    if ({done_b, sum_b, cyc_b} !== {1'b1, model_sum(1), 32'd16}) begin
      nerr++; $display("FAIL to_end: got done=%0d sum=%h cyc=%0d expected 1 %h 16", done_b, sum_b, cyc_b, model_sum(1));
    end
  endtask

  task automatic test_timeout_race();
    int cyc, herr; bit hb;
    logic [31:0] s;
    sel_g = 1; fill_regs(1, 1'b1); do_reset();
    repeat (15) tick();
    finish_b = 1'b1;
    tick();
    nchk++;
    if ({to_b, cyc_b} !== {1'b0, 32'd15}) begin nerr++; $display("FAIL race: got to=%0d cyc=%0d expected 0 15", to_b, cyc_b); end
    collect(0, 32, 200, cyc, herr, hb);
    s = model_sum(1);
    finish_b = 1'b0; repeat (5) tick();
    finish_b = 1'b1; repeat (5) tick();
    nchk++;
    if ({done_b, valid_b, cyc_b, to_b, sum_b} !== {1'b1, 1'b0, 32'd15, 1'b0, s}) begin
      nerr++; $display("FAIL race_done: got done=%0d v=%0d cyc=%0d to=%0d sum=%h expected 1 0 15 0 %h",
        done_b, valid_b, cyc_b, to_b, sum_b, s);
    end
  endtask

  task automatic test_reset_mid_dump();
    int cyc, herr; bit hb;
    sel_g = 0; fill_regs(0, 1'b1); do_reset();
    repeat (4) tick();
    finish_a = 1'b1;
    collect(2, 5, 400, cyc, herr, hb);
    nchk++;
    if (q_data.size() !== 5) begin nerr++; $display("FAIL mid_beats: got %0d expected 5", q_data.size()); end
    rst_n = 1'b0;
    #1;
    nchk++;
    if ({rdtaddr_a, valid_a, data_a, idx_a, last_a, cyc_a, to_a, sum_a, done_a} !== '0) begin
      nerr++; $display("FAIL mid_reset: got %h expected 0",
        {rdtaddr_a, valid_a, data_a, idx_a, last_a, cyc_a, to_a, sum_a, done_a});
    end
    do_reset();
    repeat (7) tick();
    nchk++;
    if (cyc_a !== 32'd7) begin nerr++; $display("FAIL mid_cnt: got %0d expected 7", cyc_a); end
    finish_a = 1'b1;
    collect(0, 32, 200, cyc, herr, hb);
    nchk++;
    if (cyc !== 34) begin nerr++; $display("FAIL mid_latency: got %0d expected 34", cyc); end
    nchk++;
    if (beat_errors(0) !== 0) begin nerr++; $display("FAIL mid_rerun: got %0d bad expected 0", beat_errors(0)); end
    nchk++;
    if (sum_a !== model_sum(0)) begin nerr++; $display("FAIL mid_sum: got %h expected %h", sum_a, model_sum(0)); end
  endtask

  task automatic test_random();
    int cyc, herr, d; bit hb;
    for (int k = 0; k < 3; k++) begin
      sel_g = 0; fill_regs(0, 1'b1); do_reset();
      d = $urandom_range(0, 20);
      repeat (d) tick();
      finish_a = 1'b1;
      collect(2, 32, 800, cyc, herr, hb);
      nchk++;
      if ({hb, herr} !== {1'b0, 32'd0}) begin nerr++; $display("FAIL rnd_flow: got budget=%0d hold=%0d expected 0 0", hb, herr); end
      nchk++;
      if (beat_errors(0) !== 0) begin nerr++; $display("FAIL rnd_beats: got %0d bad expected 0", beat_errors(0)); end
      nchk++;
      if ({cyc_a, sum_a, done_a} !== {32'(d), model_sum(0), 1'b1}) begin
        nerr++; $display("FAIL rnd_end: got cyc=%0d sum=%h done=%0d expected %0d %h 1", cyc_a, sum_a, done_a, d, model_sum(0));
      end
    end
  endtask

  initial begin
    sel_g = 0; rst_n = 1'b0; finish_a = 1'b0; finish_b = 1'b0; ready_g = 1'b0;
    fill_regs(0, 1'b0); fill_regs(1, 1'b0);
    test_reset();
    test_finish_run();
    test_ready_toggle();
    test_stall();
    test_timeout();
    test_timeout_race();
    test_reset_mid_dump();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
